// File: rtl/score_ctrl.sv
// score_ctrl: air-hockey game-flow controller.
// Arbitrates goal pulses, keeps BCD scores, enforces a post-goal hold-off
// and detects the winning score.
module score_ctrl #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic [3:0] p1_ones,
  output logic [2:0] p1_tens,
  output logic [3:0] p2_ones,
  output logic [2:0] p2_tens,
  output logic       playing,
  output logic       goal_flash,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [6:0] p1_next;
  logic [6:0] p2_next;
  logic       p1_wins;
  logic       p2_wins;

  // BCD increment of {tens, ones}; a score of 79 stays put.
  function automatic logic [6:0] bcd_inc(input logic [2:0] tens, input logic [3:0] ones);
    logic [6:0] r;
    if (tens == 3'd7 && ones == 4'd9)
      r = {tens, ones};
    else if (ones == 4'd9)
      r = {tens + 3'd1, 4'd0};
    else
      r = {tens, ones + 4'd1};
    return r;
  endfunction

  function automatic int unsigned bcd_val(input logic [6:0] s);
    return int'(s[6:4]) * 10 + int'(s[3:0]);
  endfunction

  // Candidate next scores and win detection for each player.
  always_comb begin
    p1_next = bcd_inc(p1_tens, p1_ones);
    p2_next = bcd_inc(p2_tens, p2_ones);
    p1_wins = (bcd_val(p1_next) == WIN_SCORE);
    p2_wins = (bcd_val(p2_next) == WIN_SCORE);
  end

  // Game state machine with registered scores and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      p1_ones    <= '0;
      p1_tens    <= '0;
      p2_ones    <= '0;
      p2_tens    <= '0;
      playing    <= 1'b0;
      goal_flash <= 1'b0;
      game_over  <= 1'b0;
      winner     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PLAY;
            p1_ones <= '0;
            p1_tens <= '0;
            p2_ones <= '0;
            p2_tens <= '0;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          // player 1 takes priority when both pulses coincide
          if (goal_p1 || goal_p2) begin
            if (goal_p1) {p1_tens, p1_ones} <= p1_next;
            else         {p2_tens, p2_ones} <= p2_next;
            if ((goal_p1 && p1_wins) || (!goal_p1 && p2_wins)) begin
              state     <= OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
              winner    <= goal_p1 ? 2'b01 : 2'b10;
            end else begin
              state      <= HOLD;
              goal_flash <= 1'b1;
              cnt        <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state      <= PLAY;
            goal_flash <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OVER: begin
          if (start) begin
            state     <= PLAY;
            p1_ones   <= '0;
            p1_tens   <= '0;
            p2_ones   <= '0;
            p2_tens   <= '0;
            playing   <= 1'b1;
            game_over <= 1'b0;
            winner    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed self-checking bench for score_ctrl.
module tb_score_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0;
  logic [3:0] p1_ones, p2_ones;
  logic [2:0] p1_tens, p2_tens;
  logic       playing, goal_flash, game_over;
  logic [1:0] winner;

  logic       s12 = 1'b0, g1_12 = 1'b0, g2_12 = 1'b0;
  logic [3:0] p1o_12, p2o_12;
  logic [2:0] p1t_12, p2t_12;
  logic       play_12, flash_12, over_12;
  logic [1:0] win_12;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  score_ctrl #(.WIN_SCORE(7), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .goal_p1(goal_p1), .goal_p2(goal_p2),
    .p1_ones(p1_ones), .p1_tens(p1_tens), .p2_ones(p2_ones), .p2_tens(p2_tens),
    .playing(playing), .goal_flash(goal_flash), .game_over(game_over), .winner(winner)
  );

  score_ctrl #(.WIN_SCORE(12), .HOLD_CYCLES(4)) dut12 (
    .clk(clk), .rst(rst), .start(s12), .goal_p1(g1_12), .goal_p2(g2_12),
    .p1_ones(p1o_12), .p1_tens(p1t_12), .p2_ones(p2o_12), .p2_tens(p2t_12),
    .playing(play_12), .goal_flash(flash_12), .game_over(over_12), .winner(win_12)
  );

  task automatic pulse(input logic s, input logic g1, input logic g2);
    start = s; goal_p1 = g1; goal_p2 = g2;
    @(posedge clk); #1;
    start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
  endtask

  task automatic pulse12(input logic s, input logic g1);
    s12 = s; g1_12 = g1;
    @(posedge clk); #1;
    s12 = 1'b0; g1_12 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pulse(0, 0, 0);
    pulse(0, 0, 0);
    rst = 1'b0;
    tests++; if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 14'd0) begin fails++; $display("FAIL reset_digits: got %h want 0", {p1_tens, p1_ones, p2_tens, p2_ones}); end
    tests++; if ({playing, goal_flash, game_over, winner} !== 5'd0) begin fails++; $display("FAIL reset_status: got %b want 00000", {playing, goal_flash, game_over, winner}); end
    tests++; if ({play_12, flash_12, over_12, win_12} !== 5'd0) begin fails++; $display("FAIL reset_status12: got %b want 00000", {play_12, flash_12, over_12, win_12}); end
  endtask

  task automatic test_start;
    pulse(0, 1, 0); // goal in IDLE ignored
    tests++; if (p1_ones !== 4'd0 || playing !== 1'b0) begin fails++; $display("FAIL idle_goal: got ones=%0d playing=%b want 0 0", p1_ones, playing); end
    pulse(1, 0, 0);
    tests++; if (playing !== 1'b1 || goal_flash !== 1'b0) begin fails++; $display("FAIL start_playing: got playing=%b flash=%b want 1 0", playing, goal_flash); end
    tests++; if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 14'd0) begin fails++; $display("FAIL start_digits: got %h want 0", {p1_tens, p1_ones, p2_tens, p2_ones}); end
  endtask

  task automatic test_single_goal;
    pulse(0, 1, 0);
    tests++; if (p1_ones !== 4'd1 || goal_flash !== 1'b1) begin fails++; $display("FAIL goal1: got ones=%0d flash=%b want 1 1", p1_ones, goal_flash); end
    pulse(0, 1, 0); // swallowed by HOLD
    tests++; if (p1_ones !== 4'd1 || goal_flash !== 1'b1) begin fails++; $display("FAIL hold_goal_ignored: got ones=%0d flash=%b want 1 1", p1_ones, goal_flash); end
    pulse(0, 0, 0);
    tests++; if (goal_flash !== 1'b1) begin fails++; $display("FAIL flash_cycle3: got %b want 1", goal_flash); end
    pulse(0, 0, 0);
    tests++; if (goal_flash !== 1'b1) begin fails++; $display("FAIL flash_cycle4: got %b want 1", goal_flash); end
    pulse(0, 0, 0);
    tests++; if (goal_flash !== 1'b0 || playing !== 1'b1) begin fails++; $display("FAIL flash_end: got flash=%b playing=%b want 0 1", goal_flash, playing); end
    pulse(0, 1, 0); // first cycle after hold
    tests++; if (p1_ones !== 4'd2 || goal_flash !== 1'b1) begin fails++; $display("FAIL goal_after_hold: got ones=%0d flash=%b want 2 1", p1_ones, goal_flash); end
    repeat (4) pulse(0, 0, 0);
  endtask

  task automatic test_simultaneous;
    pulse(0, 1, 1);
    tests++; if (p1_ones !== 4'd3 || p2_ones !== 4'd0 || p2_tens !== 3'd0) begin fails++; $display("FAIL simul_goal: got p1=%0d p2=%0d want 3 0", p1_ones, p2_ones); end
    repeat (4) pulse(0, 0, 0);
    pulse(1, 0, 1); // start ignored in PLAY, goal counts
    tests++; if (p1_ones !== 4'd3 || p2_ones !== 4'd1 || goal_flash !== 1'b1) begin fails++; $display("FAIL start_in_play: got p1=%0d p2=%0d flash=%b want 3 1 1", p1_ones, p2_ones, goal_flash); end
    repeat (4) pulse(0, 0, 0);
  endtask

  task automatic test_win;
    for (int i = 2; i <= 6; i++) begin
      pulse(0, 0, 1);
      tests++; if (p2_ones !== 4'(i) || game_over !== 1'b0 || goal_flash !== 1'b1) begin fails++; $display("FAIL p2_score_%0d: got ones=%0d over=%b flash=%b", i, p2_ones, game_over, goal_flash); end
      repeat (4) pulse(0, 0, 0);
    end
    pulse(0, 0, 1);
    tests++; if (p2_ones !== 4'd7 || game_over !== 1'b1 || winner !== 2'b10) begin fails++; $display("FAIL win: got ones=%0d over=%b winner=%b want 7 1 10", p2_ones, game_over, winner); end
    tests++; if (goal_flash !== 1'b0 || playing !== 1'b0) begin fails++; $display("FAIL win_no_hold: got flash=%b playing=%b want 0 0", goal_flash, playing); end
    pulse(0, 1, 1);
    tests++; if (p1_ones !== 4'd3 || p2_ones !== 4'd7 || winner !== 2'b10 || game_over !== 1'b1) begin fails++; $display("FAIL over_frozen: got p1=%0d p2=%0d winner=%b want 3 7 10", p1_ones, p2_ones, winner); end
    pulse(1, 1, 0); // start wins over goal in OVER
    tests++; if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 14'd0 || winner !== 2'b00) begin fails++; $display("FAIL restart: got digits=%h winner=%b want 0 00", {p1_tens, p1_ones, p2_tens, p2_ones}, winner); end
    tests++; if (playing !== 1'b1 || game_over !== 1'b0 || goal_flash !== 1'b0) begin fails++; $display("FAIL restart_status: got playing=%b over=%b flash=%b want 1 0 0", playing, game_over, goal_flash); end
  endtask

  task automatic test_bcd_carry;
    pulse12(1, 0);
    for (int i = 1; i <= 9; i++) begin
      pulse12(0, 1);
      repeat (4) pulse12(0, 0);
    end
    tests++; if (p1t_12 !== 3'd0 || p1o_12 !== 4'd9) begin fails++; $display("FAIL score9: got %0d%0d want 09", p1t_12, p1o_12); end
    pulse12(0, 1);
    tests++; if (p1t_12 !== 3'd1 || p1o_12 !== 4'd0 || flash_12 !== 1'b1) begin fails++; $display("FAIL carry10: got %0d%0d flash=%b want 10 1", p1t_12, p1o_12, flash_12); end
    repeat (4) pulse12(0, 0);
    pulse12(0, 1);
    tests++; if (p1t_12 !== 3'd1 || p1o_12 !== 4'd1 || over_12 !== 1'b0) begin fails++; $display("FAIL score11: got %0d%0d over=%b want 11 0", p1t_12, p1o_12, over_12); end
    repeat (4) pulse12(0, 0);
    pulse12(0, 1);
    tests++; if (p1o_12 !== 4'd2 || over_12 !== 1'b1 || win_12 !== 2'b01) begin fails++; $display("FAIL win12: got ones=%0d over=%b winner=%b want 2 1 01", p1o_12, over_12, win_12); end
  endtask

  task automatic test_reset_mid_hold;
    pulse(0, 1, 0);
    pulse(0, 0, 0);
    tests++; if (goal_flash !== 1'b1 || p1_ones !== 4'd1) begin fails++; $display("FAIL pre_reset_hold: got flash=%b ones=%0d want 1 1", goal_flash, p1_ones); end
    rst = 1'b1;
    pulse(0, 0, 0);
    rst = 1'b0;
    tests++; if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 14'd0 || {playing, goal_flash, game_over, winner} !== 5'd0) begin fails++; $display("FAIL mid_hold_reset: got digits=%h status=%b want 0 0", {p1_tens, p1_ones, p2_tens, p2_ones}, {playing, goal_flash, game_over, winner}); end
    pulse(0, 1, 0);
    tests++; if (p1_ones !== 4'd0 || playing !== 1'b0) begin fails++; $display("FAIL idle_after_reset: got ones=%0d playing=%b want 0 0", p1_ones, playing); end
    pulse(1, 0, 0);
    pulse(0, 0, 1); // goal right after start is accepted
    tests++; if (p2_ones !== 4'd1 || goal_flash !== 1'b1) begin fails++; $display("FAIL goal_after_start: got ones=%0d flash=%b want 1 1", p2_ones, goal_flash); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_start;
    test_single_goal;
    test_simultaneous;
    test_win;
    test_bcd_carry;
    test_reset_mid_hold;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
